// File: rtl/fccc_pkg.sv
// Shared definitions for the fabric CCC lock qualifier and clock-enable generator.
// FSM state codes, default divide vector and the synchroniser depth.
package fccc_pkg;

  typedef logic [1:0] fccc_state_t;

  localparam fccc_state_t ST_WAIT_LOCK = 2'd0;
  localparam fccc_state_t ST_STABILISE = 2'd1;
  localparam fccc_state_t ST_RUN       = 2'd2;
  localparam fccc_state_t ST_LOST      = 2'd3;

  // Two flops are enough to bring the asynchronous PLL LOCK into the GL0 domain.
  localparam int FCCC_SYNC_STAGES = 2;

  // Channel 0 runs at full rate, then /2, /4, /8.
  localparam logic [63:0] FCCC_DIV_VEC_DEF = {16'd8, 16'd4, 16'd2, 16'd1};

endpackage

// File: rtl/fccc_lock_clken_gen_div.sv
// Single-channel clock-enable divider. Counts 0..div-1 while running and emits
// a registered one-cycle strobe on every wrap. A divide value of 0 acts as 1.
module fccc_clken_div #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_stb
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stb;
  logic [CNT_W-1:0] w_last;
  logic             w_wrap;

  assign w_last = (i_div == '0) ? '0 : (i_div - CNT_W'(1));
  assign w_wrap = (r_cnt == w_last);
  assign o_stb  = r_stb;

  // Counter and strobe; held at zero whenever the channel is not running so no partial strobe escapes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_stb <= 1'b0;
    end else if (i_clear || !i_run) begin
      r_cnt <= '0;
      r_stb <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_stb <= 1'b1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_stb <= 1'b0;
    end
  end

endmodule

// File: rtl/fccc_lock_clken_gen.sv
// Fabric CCC lock qualifier: synchronises PLL LOCK, waits for a stable lock,
// then releases the fabric reset and runs NUM_CH phase-aligned clock-enable strobes.
// Optional lock-loss counter enabled by defining FCCC_LOSS_COUNTER_EN.
module fccc_lock_clken_gen
  import fccc_pkg::*;
#(
  parameter int                       NUM_CH          = 4,
  parameter int                       CNT_W           = 16,
  parameter logic [NUM_CH*CNT_W-1:0]  DIV_VEC         = FCCC_DIV_VEC_DEF,
  parameter int                       LOCK_STABLE_CYC = 1024,
  parameter int                       LOSS_CNT_W      = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOCK,
  output logic              LOCK_OK,
  output logic              FABRIC_RESET,
  output logic [NUM_CH-1:0] CLKEN
`ifdef FCCC_LOSS_COUNTER_EN
  ,
  output logic [LOSS_CNT_W-1:0] LOSS_CNT
`endif
);

  localparam int STB_W = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;

  logic [FCCC_SYNC_STAGES-1:0] r_sync;
  logic                        w_lock_s;
  fccc_state_t                 r_state;
  fccc_state_t                 w_next;
  logic [STB_W-1:0]            r_stb_cnt;
  logic                        r_lock_ok;
  logic                        r_fabric_reset;
  logic                        w_div_run;
  logic                        w_div_clear;

  assign w_lock_s = r_sync[FCCC_SYNC_STAGES-1];

  // LOCK synchroniser.
  always_ff @(posedge CLK) begin
    if (RESET) r_sync <= '0;
    else       r_sync <= {r_sync[FCCC_SYNC_STAGES-2:0], LOCK};
  end

  // Next-state decode; a lock drop on the final stabilise cycle wins over entering RUN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT_LOCK: if (w_lock_s) w_next = ST_STABILISE;
      ST_STABILISE: begin
        if (!w_lock_s)                                         w_next = ST_WAIT_LOCK;
        else if (r_stb_cnt == STB_W'(LOCK_STABLE_CYC - 1))     w_next = ST_RUN;
      end
      ST_RUN:       if (!w_lock_s) w_next = ST_LOST;
      default:      w_next = ST_WAIT_LOCK;
    endcase
  end

  // State, stable counter and outputs registered from the next state so they move on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state        <= ST_WAIT_LOCK;
      r_stb_cnt      <= '0;
      r_lock_ok      <= 1'b0;
      r_fabric_reset <= 1'b1;
    end else begin
      r_state        <= w_next;
      r_stb_cnt      <= (r_state == ST_STABILISE && w_next == ST_STABILISE) ? r_stb_cnt + STB_W'(1) : '0;
      r_lock_ok      <= (w_next == ST_RUN);
      r_fabric_reset <= (w_next != ST_RUN);
    end
  end

  assign LOCK_OK      = r_lock_ok;
  assign FABRIC_RESET = r_fabric_reset;

  // Dividers run only while staying in RUN, and restart together on RUN entry.
  assign w_div_run   = (r_state == ST_RUN) && (w_next == ST_RUN);
  assign w_div_clear = (r_state != ST_RUN) && (w_next == ST_RUN);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fccc_clken_div #(
      .CNT_W (CNT_W)
    ) u_div (
      .i_clk   (CLK),
      .i_rst   (RESET),
      .i_clear (w_div_clear),
      .i_run   (w_div_run),
      .i_div   (DIV_VEC[g*CNT_W +: CNT_W]),
      .o_stb   (CLKEN[g])
    );
  end

`ifdef FCCC_LOSS_COUNTER_EN
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  // Saturating count of RUN->LOST transitions; only RESET clears it.
  always_ff @(posedge CLK) begin
    if (RESET)
      r_loss_cnt <= '0;
    else if (r_state == ST_RUN && w_next == ST_LOST && r_loss_cnt != '1)
      r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
  end

  assign LOSS_CNT = r_loss_cnt;
`endif

endmodule
